// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit framer state type.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide combinational CRC-32 step (reflected IEEE polynomial), LSB of data first.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data_in[i]) begin
        crc_out = (crc_out >> 1) ^ ETH_CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS, inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes before the FCS.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12,
  parameter int unsigned MIN_FRAME    = 60
) (
  input  logic       clk_125,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy
);

  localparam int unsigned CntW = 8;

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [31:0]     crc_q, crc_d, crc_next, fcs_word;
  logic [7:0]      crc_byte, tx_data_d;
  logic            tx_en_d, tx_er_d, short_frame;

  assign s_ready      = (state_q == DATA);
  assign crc_byte     = (state_q == DATA) ? s_data : 8'h00;
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  // True while the byte going out now still leaves the frame below minimum length.
  assign short_frame  = (32'(byte_cnt_q) + 32'd1) < MIN_FRAME;
  assign fcs_word     = ~crc_q >> {cnt_q[1:0], 3'b000};

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data_in (crc_byte),
    .crc_out (crc_next)
  );

`ifndef ETH_TX_PAD_EN
  logic unused_short_frame;
  assign unused_short_frame = short_frame;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    tx_data_d  = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // First preamble byte leaves on the edge that sees s_valid.
        if (s_valid) begin
          tx_en_d   = 1'b1;
          tx_data_d = ETH_PREAMBLE_BYTE;
          cnt_d     = CntW'(1);
          state_d   = (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
        end
      end
      PREAMBLE: begin
        tx_en_d   = 1'b1;
        tx_data_d = ETH_PREAMBLE_BYTE;
        if (cnt_q == CntW'(PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = SFD;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SFD: begin
        tx_en_d    = 1'b1;
        tx_data_d  = ETH_SFD_BYTE;
        crc_d      = ETH_CRC_INIT;
        byte_cnt_d = '0;
        state_d    = DATA;
      end
      DATA: begin
        tx_en_d = 1'b1;
        cnt_d   = '0;
        if (s_valid) begin
          tx_data_d  = s_data;
          tx_er_d    = s_err;
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
          if (s_last) begin
`ifdef ETH_TX_PAD_EN
            state_d = short_frame ? PAD : FCS;
`else
            state_d = FCS;
`endif
          end
        end else begin
          // Underrun: poison the frame and skip the FCS.
          tx_er_d = 1'b1;
          state_d = IFG;
        end
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next;
        byte_cnt_d = byte_cnt_inc;
        if (!short_frame) begin
          state_d = FCS;
        end
      end
`endif
      FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_word[7:0];
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d   = '0;
          state_d = IFG;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      IFG: begin
        if (cnt_q == CntW'(IFG_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= ETH_CRC_INIT;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      tx_data    <= tx_data_d;
      tx_en      <= tx_en_d;
      tx_er      <= tx_er_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: random payloads against a frame-level reference model.
module tb_gmii_tx_framer;

`ifdef ETH_TX_PAD_EN
  localparam bit PadOn = 1'b1;
`else
  localparam bit PadOn = 1'b0;
`endif

  logic       clk_125 = 1'b0;
  logic       rst_n   = 1'b1;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic       s_err   = 1'b0;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_en, tx_er, busy;

  gmii_tx_framer dut (
    .clk_125 (clk_125),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_err   (s_err),
    .s_ready (s_ready),
    .tx_data (tx_data),
    .tx_en   (tx_en),
    .tx_er   (tx_er),
    .busy    (busy)
  );

  always #4 clk_125 = ~clk_125;

  int n_cmp = 0;
  int n_bad = 0;

  bit         mon_on = 1'b0;
  logic [9:0] cap[$];     // {en, er, data} per cycle
  logic [8:0] exp_q[$];   // expected {er, data} of every tx_en=1 cycle
  logic [8:0] got[$];
  int         gaps[$];
  int         runs, dirty;
  logic [7:0] fr_data[$];
  logic       fr_err[$];

  always @(negedge clk_125) if (mon_on) cap.push_back({tx_en, tx_er, tx_data});

  task automatic start_test();
    cap.delete();
    exp_q.delete();
    mon_on = 1'b1;
  endtask

  task automatic make_frame(input int n, input int err_at);
    fr_data.delete();
    fr_err.delete();
    for (int i = 0; i < n; i++) begin
      fr_data.push_back(8'($urandom_range(0, 255)));
      fr_err.push_back(i == err_at);
    end
  endtask

  // Reference model: what the wire must carry for the current frame buffer.
  task automatic model_frame(input int ua);
    logic [7:0]  body[$];
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (ua >= 0) begin
      for (int i = 0; i < ua; i++) exp_q.push_back({fr_err[i], fr_data[i]});
      exp_q.push_back({1'b1, 8'h00});
      return;
    end
    foreach (fr_data[i]) begin
      body.push_back(fr_data[i]);
      exp_q.push_back({fr_err[i], fr_data[i]});
    end
    while (PadOn && body.size() < 60) begin
      body.push_back(8'h00);
      exp_q.push_back({1'b0, 8'h00});
    end
    foreach (body[k]) begin
      c = c ^ {24'h0, body[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, c[7:0]});
      c = c >> 8;
    end
  endtask

  // Drives fr_data from a negedge; ua >= 0 drops s_valid at that byte and abandons the frame.
  task automatic send_frame(input int ua);
    int i = 0;
    int g = 0;
    int n = fr_data.size();
    bit acc;
    bit aborted = 1'b0;
    model_frame(ua);
    while (i < n && !aborted && g < 4000) begin
      if (ua >= 0 && i == ua && s_ready) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
        aborted = 1'b1;
      end else begin
        s_valid = 1'b1;
        s_data  = fr_data[i];
        s_last  = (i == n - 1);
        s_err   = fr_err[i];
      end
      acc = s_ready && !aborted;
      @(negedge clk_125);
      g++;
      if (acc) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_err   = 1'b0;
    n_cmp++;
    if (!(i == n || aborted)) begin
      n_bad++;
      $display("FAIL send_frame timeout: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    repeat (2) @(negedge clk_125);
    while (busy && g < 3000) begin
      @(negedge clk_125);
      g++;
    end
    repeat (4) @(negedge clk_125);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, g);
    end
  endtask

  // Splits the capture into tx_en runs, inter-run idle gaps and dirty idle cycles.
  task automatic analyze();
    int idle = 0;
    bit prev = 1'b0;
    got.delete();
    gaps.delete();
    runs  = 0;
    dirty = 0;
    foreach (cap[k]) begin
      if (cap[k][9]) begin
        if (!prev && runs > 0) gaps.push_back(idle);
        if (!prev) runs++;
        got.push_back(cap[k][8:0]);
        idle = 0;
      end else begin
        idle++;
        if (cap[k][8:0] != 9'h0) dirty++;
      end
      prev = cap[k][9];
    end
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #10;
    n_cmp++; if (tx_en !== 1'b0)   begin n_bad++; $display("FAIL reset tx_en: got %b want 0", tx_en); end
    n_cmp++; if (tx_er !== 1'b0)   begin n_bad++; $display("FAIL reset tx_er: got %b want 0", tx_er); end
    n_cmp++; if (tx_data !== 8'h0) begin n_bad++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset s_ready: got %b want 0", s_ready); end
    @(negedge clk_125);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_125);
  endtask

  task automatic test_known_vector();
    logic [7:0] fcs_ref[4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    int len_ref = PadOn ? 72 : 21;
    start_test();
    fr_data.delete();
    fr_err.delete();
    for (int i = 0; i < 9; i++) begin
      fr_data.push_back(8'h31 + 8'(i));
      fr_err.push_back(1'b0);
    end
    send_frame(-1);
    wait_idle();
    analyze();
    n_cmp++; if (got.size() != len_ref) begin n_bad++; $display("FAIL known tx_en length: got %0d want %0d", got.size(), len_ref); end
    n_cmp++; if (runs != 1) begin n_bad++; $display("FAIL known runs: got %0d want 1", runs); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL known byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
    if (!PadOn && got.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got[got.size() - 4 + k] !== {1'b0, fcs_ref[k]}) begin
          n_bad++; $display("FAIL known fcs %0d: got %h want %h", k, got[got.size() - 4 + k], fcs_ref[k]);
        end
      end
    end
  endtask

  task automatic test_pad();
    int len_ref = PadOn ? 72 : 26;
    start_test();
    make_frame(14, -1);
    send_frame(-1);
    wait_idle();
    analyze();
    n_cmp++; if (got.size() != len_ref) begin n_bad++; $display("FAIL pad tx_en length: got %0d want %0d", got.size(), len_ref); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL pad model length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL pad byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    make_frame(64, -1);
    send_frame(-1);
    make_frame(64, -1);
    send_frame(-1);
    wait_idle();
    analyze();
    n_cmp++; if (runs != 2) begin n_bad++; $display("FAIL b2b runs: got %0d want 2", runs); end
    n_cmp++; if (gaps.size() != 1 || gaps[0] != 12) begin
      n_bad++; $display("FAIL b2b gap: got %0d want 12", (gaps.size() > 0) ? gaps[0] : -1);
    end
    n_cmp++; if (dirty != 0) begin n_bad++; $display("FAIL b2b idle bus: got %0d dirty cycles want 0", dirty); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL b2b byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  task automatic test_underrun();
    start_test();
    make_frame(40, -1);
    send_frame(20);
    make_frame(30, -1);
    send_frame(-1);
    wait_idle();
    analyze();
    n_cmp++; if (runs != 2) begin n_bad++; $display("FAIL underrun runs: got %0d want 2", runs); end
    n_cmp++; if (gaps.size() != 1 || gaps[0] != 12) begin
      n_bad++; $display("FAIL underrun gap: got %0d want 12", (gaps.size() > 0) ? gaps[0] : -1);
    end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL underrun length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL underrun byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  task automatic test_err();
    int ec = 0;
    start_test();
    make_frame(30, 5);
    send_frame(-1);
    wait_idle();
    analyze();
    foreach (got[k]) if (got[k][8]) ec++;
    n_cmp++; if (ec != 1) begin n_bad++; $display("FAIL err count: got %0d tx_er cycles want 1", ec); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL err length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL err byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  task automatic test_random();
    int n, ea, sp;
    start_test();
    for (int f = 0; f < 6; f++) begin
      n  = int'($urandom_range(1, 100));
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      make_frame(n, ea);
      send_frame(-1);
      sp = int'($urandom_range(0, 20));
      repeat (sp) @(negedge clk_125);
    end
    wait_idle();
    analyze();
    n_cmp++; if (runs != 6) begin n_bad++; $display("FAIL random runs: got %0d want 6", runs); end
    foreach (gaps[k]) begin
      n_cmp++;
      if (gaps[k] < 12) begin n_bad++; $display("FAIL random gap %0d: got %0d want >=12", k, gaps[k]); end
    end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL random length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL random byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 14; i++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_err   = 1'b0;
      s_data  = 8'($urandom_range(0, 255));
      @(negedge clk_125);
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset busy before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_en !== 1'b0)   begin n_bad++; $display("FAIL midreset tx_en: got %b want 0", tx_en); end
    n_cmp++; if (tx_er !== 1'b0)   begin n_bad++; $display("FAIL midreset tx_er: got %b want 0", tx_er); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL midreset busy: got %b want 0", busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL midreset s_ready: got %b want 0", s_ready); end
    s_valid = 1'b0;
    @(negedge clk_125);
    rst_n = 1'b1;
    @(negedge clk_125);
    start_test();
    make_frame(20, -1);
    send_frame(-1);
    wait_idle();
    analyze();
    n_cmp++; if (runs != 1) begin n_bad++; $display("FAIL midreset runs: got %0d want 1", runs); end
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL midreset length: got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin n_bad++; $display("FAIL midreset byte %0d: got %h want %h", k, got[k], exp_q[k]); break; end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_err();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
